decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 The block SHALL have parameter SEL_W, default 3, giving the select width; OUT_W = 2**SEL_W is derived and not overridable.
REQ-002 The block SHALL have parameter PERIOD, default 4, giving the cycles per scan step; legal range 1..65535.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 0; when 1, every y bit is inverted at the output.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: global enable; when 0, all state holds.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 selects DECODE, 1 selects SCAN.
REQ-008 The block SHALL have port load, input, 1 bit: strobe that samples i in DECODE.
REQ-009 The block SHALL have port i, input, SEL_W bits: select value.
REQ-010 The block SHALL have port y, output, OUT_W bits: registered one-hot (or all-inactive) output.
REQ-011 The block SHALL have port idx, output, SEL_W bits: currently active channel index.
REQ-012 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when a scan wraps from OUT_W-1 to 0.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, DECODE and SCAN, updated only when en=1.
REQ-014 IDLE SHALL go to DECODE when mode=0 and load=1, and to SCAN when mode=1; SCAN SHALL go to DECODE when mode=0; DECODE SHALL go to SCAN when mode=1.
REQ-015 In DECODE, with en=1 and load=1, the block SHALL set y[i] active, all other bits inactive, and idx=i one cycle later (latency 1).
REQ-016 In DECODE, with load=0, y and idx SHALL hold.
REQ-017 On entering SCAN, idx SHALL restart at 0, y[0] SHALL go active, and the step counter SHALL clear.
REQ-018 In SCAN, idx SHALL advance by 1 every PERIOD enabled cycles, and y SHALL follow idx.
REQ-019 On the step from idx=OUT_W-1, idx SHALL wrap to 0 and wrap SHALL pulse high for exactly one cycle, coincident with the y update.
REQ-020 With PERIOD=1, idx SHALL advance every enabled cycle.
REQ-021 When en=0, the step counter SHALL freeze and wrap SHALL be 0.
REQ-022 y SHALL have at most one active bit in every cycle.
REQ-023 If mode changes and load=1 in the same cycle, the mode change SHALL take priority and load SHALL be ignored that cycle.

Reset
REQ-024 While rst_n=0, the block SHALL asynchronously force state=IDLE, y to all inactive (all 0, or all 1 if ACTIVE_LOW), idx=0, wrap=0 and step counter=0.
REQ-025 A reset asserted mid-scan SHALL abort the scan, and after release the block SHALL sit in IDLE until the REQ-014 conditions hold.

Configuration
REQ-026 When macro DECODER_SCAN_MASK_EN is defined, the block SHALL add input port mask[OUT_W-1:0], where a 1 disables that channel.
REQ-027 With DECODER_SCAN_MASK_EN defined, SCAN SHALL skip masked channels, and a DECODE of a masked channel SHALL produce all-inactive y with idx=i.
REQ-028 With DECODER_SCAN_MASK_EN defined and all channels masked, SCAN SHALL hold y all-inactive, hold idx, and never pulse wrap.
REQ-029 With DECODER_SCAN_MASK_EN undefined, the mask port SHALL be absent and the behaviour SHALL equal mask=0.

Structure
REQ-030 A shared package decoder_pkg SHALL hold the state typedef (IDLE/DECODE/SCAN) and the mode constants MODE_DECODE=0 and MODE_SCAN=1.
REQ-031 The block SHALL contain one sub-module, scan_timer, a PERIOD-cycle step counter with clear and enable that emits a step pulse.

Verification
REQ-032 The bench SHALL apply reset, then SEL_W=3, mode=0, load=1, sweep i=0..7, and check y=00000001 through 10000000, each one cycle after its load.
REQ-033 The bench SHALL run mode=1 with PERIOD=4 for 40 cycles, and check idx steps 0..7 every 4 cycles and wrap high exactly once at cycle 32.
REQ-034 The bench SHALL hold en=0 for 5 cycles mid-scan at idx=3, and check idx=3 holds and the step timing resumes with no lost count.
REQ-035 The bench SHALL assert rst_n=0 asynchronously mid-scan at idx=5, and check y=0 and idx=0 immediately (before the next edge), then IDLE after release.
REQ-036 With DECODER_SCAN_MASK_EN defined and mask=8'b0010_0110, the bench SHALL check SCAN visits idx 0,3,4,6,7,0; then mask=8'hFF SHALL give y=0 with wrap never pulsing.
REQ-037 With ACTIVE_LOW=1, SEL_W=4 and i=9 in DECODE, the bench SHALL check y=16'hFDFF.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decoder_pkg
// Purpose  : Shared FSM state encoding and mode constants for decoder_scan.
// Revision : 1.0 - initial release
// ============================================================================
package decoder_pkg;

   // FSM state encoding with an explicit 2-bit width
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      SCAN   = 2'd2
   } state_t;

   // Values of the mode input
   localparam logic MODE_DECODE = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/decoder_scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : scan_timer
// Purpose  : PERIOD-cycle step counter with synchronous clear and enable.
//            Emits a one-cycle step pulse on the last count of each period.
// Revision : 1.0 - initial release
// ============================================================================
module scan_timer #(
   parameter int PERIOD = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic step
);

   localparam int              CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] r_cnt;

   // The step fires on the final count of an enabled period; clear wins
   assign step = en && !clr && (r_cnt == c_LAST);

   // Count enabled cycles, rolling over at PERIOD-1; frozen while en is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/decoder_scan.sv
`default_nettype none
// ============================================================================
// Module   : decoder_scan
// Purpose  : Registered one-hot decoder with an auto-scan mode. DECODE loads
//            the select on a strobe; SCAN walks the channels every PERIOD
//            enabled cycles and pulses wrap when it returns to channel 0.
//            Optional macro DECODER_SCAN_MASK_EN adds a per-channel mask
//            input (1 = channel disabled).
// Revision : 1.0 - initial release
// ============================================================================
module decoder_scan
   import decoder_pkg::*;
#(
   parameter  int SEL_W      = 3,
   parameter  int PERIOD     = 4,
   parameter  bit ACTIVE_LOW = 1'b0,
   localparam int OUT_W      = 2**SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [SEL_W-1:0] i,
`ifdef DECODER_SCAN_MASK_EN
   input  logic [OUT_W-1:0] mask,
`endif
   output logic [OUT_W-1:0] y,
   output logic [SEL_W-1:0] idx,
   output logic             wrap
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEL_W-1:0] r_idx;
   logic [OUT_W-1:0] r_y_act;
   logic             r_wrap;

   logic [OUT_W-1:0] w_mask;
   logic             w_enter_scan;
   logic             w_scan_run;
   logic             w_do_load;
   logic             w_step;
   logic [SEL_W-1:0] w_step_idx;
   logic             w_step_ok;
   logic [SEL_W-1:0] w_first_idx;
   logic             w_first_ok;
   logic [SEL_W-1:0] w_idx_nxt;
   logic [OUT_W-1:0] w_y_nxt;
   logic             w_wrap_nxt;

`ifdef DECODER_SCAN_MASK_EN
   assign w_mask = mask;
`else
   assign w_mask = '0;
`endif

   function automatic logic [OUT_W-1:0] f_onehot(input logic [SEL_W-1:0] s);
      f_onehot    = '0;
      f_onehot[s] = 1'b1;
   endfunction

   // A mode change always beats load: loads only happen while staying in/entering DECODE
   assign w_enter_scan = en && (r_state != SCAN) && (mode == MODE_SCAN);
   assign w_scan_run   = en && (r_state == SCAN) && (mode == MODE_SCAN);
   assign w_do_load    = en && load && (mode == MODE_DECODE) &&
                         ((r_state == IDLE) || (r_state == DECODE));

   scan_timer #(
      .PERIOD (PERIOD)
   ) u_scan_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_enter_scan),
      .en    (w_scan_run),
      .step  (w_step)
   );

   // Find the next unmasked channel after r_idx (circular) and the first from 0
   always_comb begin
      logic [SEL_W-1:0] w_cand;
      w_cand      = '0;
      w_step_idx  = r_idx;
      w_step_ok   = 1'b0;
      w_first_idx = '0;
      w_first_ok  = 1'b0;
      // Descending loops so the nearest candidate is the one that sticks
      for (int k = OUT_W; k >= 1; k--) begin
         w_cand = r_idx + SEL_W'(k);
         if (!w_mask[w_cand]) begin
            w_step_idx = w_cand;
            w_step_ok  = 1'b1;
         end
      end
      for (int j = OUT_W - 1; j >= 0; j--) begin
         if (!w_mask[SEL_W'(j)]) begin
            w_first_idx = SEL_W'(j);
            w_first_ok  = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; nothing moves while en is low
   always_comb begin
      w_state_nxt = r_state;
      if (en) begin
         case (r_state)
            IDLE: begin
               if (mode == MODE_SCAN) begin
                  w_state_nxt = SCAN;
               end else if (load) begin
                  w_state_nxt = DECODE;
               end
            end
            DECODE: begin
               if (mode == MODE_SCAN) begin
                  w_state_nxt = SCAN;
               end
            end
            SCAN: begin
               if (mode == MODE_DECODE) begin
                  w_state_nxt = DECODE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Output next-values: scan entry, scan stepping, or decode load
   always_comb begin
      w_idx_nxt  = r_idx;
      w_y_nxt    = r_y_act;
      w_wrap_nxt = 1'b0;
      if (w_enter_scan) begin
         w_idx_nxt = w_first_idx;
         w_y_nxt   = w_first_ok ? f_onehot(w_first_idx) : '0;
      end else if (w_scan_run) begin
         if (w_step && w_step_ok) begin
            w_idx_nxt  = w_step_idx;
            w_y_nxt    = f_onehot(w_step_idx);
            // Landing at or below the current index means the scan went round
            w_wrap_nxt = (w_step_idx <= r_idx);
         end else begin
            // Refresh so a channel masked mid-scan goes inactive promptly
            w_y_nxt = f_onehot(r_idx) & ~w_mask;
         end
      end else if (w_do_load) begin
         w_idx_nxt = i;
         w_y_nxt   = f_onehot(i) & ~w_mask;
      end
   end

   // Output registers (active-high internally)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx   <= '0;
         r_y_act <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_idx   <= w_idx_nxt;
         r_y_act <= w_y_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   generate
      if (ACTIVE_LOW) begin : g_y_active_low
         assign y = ~r_y_act;
      end else begin : g_y_active_high
         assign y = r_y_act;
      end
   endgenerate

   assign idx  = r_idx;
   assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_scan
// Purpose  : Directed self-checking bench for decoder_scan (SEL_W=3, PERIOD=4)
//            plus an ACTIVE_LOW, SEL_W=4 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_scan;
   import decoder_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        en, mode, load;
   logic [2:0]  i;
   logic [7:0]  y;
   logic [2:0]  idx;
   logic        wrap;
`ifdef DECODER_SCAN_MASK_EN
   logic [7:0]  mask;
   logic [15:0] al_mask;
`endif

   logic        al_en, al_mode, al_load;
   logic [3:0]  al_i;
   logic [15:0] al_y;
   logic [3:0]  al_idx;
   logic        al_wrap;

   int checks   = 0;
   int failures = 0;

   decoder_scan #(.SEL_W(3), .PERIOD(4), .ACTIVE_LOW(1'b0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mode  (mode),
      .load  (load),
      .i     (i),
`ifdef DECODER_SCAN_MASK_EN
      .mask  (mask),
`endif
      .y     (y),
      .idx   (idx),
      .wrap  (wrap)
   );

   decoder_scan #(.SEL_W(4), .PERIOD(4), .ACTIVE_LOW(1'b1)) dut_al (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (al_en),
      .mode  (al_mode),
      .load  (al_load),
      .i     (al_i),
`ifdef DECODER_SCAN_MASK_EN
      .mask  (al_mask),
`endif
      .y     (al_y),
      .idx   (al_idx),
      .wrap  (al_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_y;
      int         wrap_cnt;
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; i = '0;
      al_en = 1'b0; al_mode = 1'b0; al_load = 1'b0; al_i = '0;
`ifdef DECODER_SCAN_MASK_EN
      mask = '0; al_mask = '0;
`endif
      // Reset state
      #12;
      chk("rst_y", 32'(y), 32'h00);
      chk("rst_idx", 32'(idx), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      chk("rst_state", 32'(dut.r_state), 32'(IDLE));
      chk("rst_al_y", 32'(al_y), 32'hFFFF);
      #1 rst_n = 1'b1;

      // Decode sweep, latency 1
      en = 1'b1; mode = MODE_DECODE; load = 1'b1;
      for (int k = 0; k < 8; k++) begin
         i = 3'(k);
         tick();
         exp_y = 8'h01 << k;
         chk("dec_y", 32'(y), 32'(exp_y));
         chk("dec_idx", 32'(idx), 32'(k));
      end
      load = 1'b0; i = 3'd3;
      tick();
      chk("dec_hold_y", 32'(y), 32'h80);
      chk("dec_hold_idx", 32'(idx), 32'd7);

      // Mode change with load: enter SCAN, load ignored
      mode = MODE_SCAN; load = 1'b1; i = 3'd2;
      tick();
      load = 1'b0;
      chk("scan_entry_idx", 32'(idx), 32'd0);
      chk("scan_entry_y", 32'(y), 32'h01);
      wrap_cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         exp_y = 8'h01 << ((c / 4) % 8);
         chk("scan_idx", 32'(idx), 32'((c / 4) % 8));
         chk("scan_y", 32'(y), 32'(exp_y));
         chk("scan_wrap", 32'(wrap), 32'(c == 32));
         if (wrap === 1'b1) wrap_cnt++;
      end
      chk("scan_wrap_count", 32'(wrap_cnt), 32'd1);

      // Back to DECODE with load: y/idx hold, then a real load
      mode = MODE_DECODE; load = 1'b1; i = 3'd6;
      tick();
      chk("to_dec_idx_hold", 32'(idx), 32'd2);
      chk("to_dec_y_hold", 32'(y), 32'h04);
      tick();
      chk("dec6_y", 32'(y), 32'h40);
      load = 1'b0;

      // Pause mid-scan at idx=3, then resume without losing count
      mode = MODE_SCAN;
      tick();
      chk("rescan_idx", 32'(idx), 32'd0);
      for (int c = 1; c <= 13; c++) tick();
      chk("pre_pause_idx", 32'(idx), 32'd3);
      en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("pause_idx", 32'(idx), 32'd3);
         chk("pause_wrap", 32'(wrap), 32'd0);
      end
      en = 1'b1;
      for (int c = 14; c <= 16; c++) begin
         tick();
         chk("resume_idx", 32'(idx), 32'(c / 4));
      end

      // Asynchronous reset mid-scan at idx=5
      for (int c = 17; c <= 20; c++) tick();
      chk("pre_rst_idx", 32'(idx), 32'd5);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_y", 32'(y), 32'h00);
      chk("async_rst_idx", 32'(idx), 32'd0);
      mode = MODE_DECODE; load = 1'b0;
      #10 rst_n = 1'b1;
      tick();
      chk("post_rst_state", 32'(dut.r_state), 32'(IDLE));
      tick();
      chk("idle_stays", 32'(dut.r_state), 32'(IDLE));
      chk("idle_y", 32'(y), 32'h00);
      load = 1'b1; i = 3'd2;
      tick();
      load = 1'b0;
      chk("idle_load_y", 32'(y), 32'h04);
      chk("idle_load_state", 32'(dut.r_state), 32'(DECODE));

      // Active-low, SEL_W=4 decode of channel 9
      al_en = 1'b1; al_mode = MODE_DECODE; al_load = 1'b1; al_i = 4'd9;
      tick();
      chk("al_y", 32'(al_y), 32'hFDFF);
      chk("al_idx", 32'(al_idx), 32'd9);

`ifdef DECODER_SCAN_MASK_EN
      // Masked decode and masked scan
      mask = 8'b0010_0110;
      mode = MODE_DECODE; load = 1'b1; i = 3'd1;
      tick();
      chk("mdec_y", 32'(y), 32'h00);
      chk("mdec_idx", 32'(idx), 32'd1);
      load = 1'b0; mode = MODE_SCAN;
      tick();
      chk("mscan_entry", 32'(idx), 32'd0);
      begin
         logic [2:0] seq [5];
         seq = '{3'd3, 3'd4, 3'd6, 3'd7, 3'd0};
         for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 4; c++) tick();
            exp_y = 8'h01 << seq[s];
            chk("mscan_idx", 32'(idx), 32'(seq[s]));
            chk("mscan_y", 32'(y), 32'(exp_y));
            chk("mscan_wrap", 32'(wrap), 32'(s == 4));
         end
      end
      mask = 8'hFF;
      mode = MODE_DECODE;
      tick();
      mode = MODE_SCAN;
      tick();
      for (int c = 0; c < 40; c++) begin
         tick();
         chk("allmask_y", 32'(y), 32'h00);
         chk("allmask_wrap", 32'(wrap), 32'd0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
